// File: rtl/rocketcpu_irqctrl_if.sv
// Register-bus bundle for rocketcpu_irqctrl: word-addressed, single-cycle ack.
// Signal names are taken from the controller's side of the bus.
interface rocketcpu_irqctrl_if;
   logic [1:0]  i_wb_adr;
   logic [31:0] i_wb_dat;
   logic        i_wb_we;
   logic        i_wb_cyc;
   logic        i_wb_stb;
   logic [31:0] o_wb_rdt;
   logic        o_wb_ack;

   modport master (
      output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
      input  o_wb_rdt, o_wb_ack
   );

   modport slave (
      input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc, i_wb_stb,
      output o_wb_rdt, o_wb_ack
   );
endinterface

// File: rtl/rocketcpu_irqctrl.sv
// Interrupt controller: PENDING/ENABLE/ACTIVE/ID registers and a registered combined o_irq.
// Define ROCKETCPU_IRQCTRL_EDGE_EN for rising-edge capture with W1C; default is level mode.
module rocketcpu_irqctrl #(
   parameter int NSRC = 8
) (
   input  logic            i_wb_clk,
   input  logic            i_wb_rst,
   input  logic [NSRC-1:0] i_irq,
   rocketcpu_irqctrl_if.slave bus,
   output logic            o_irq
);

   logic [NSRC-1:0] r_pending;
   logic [NSRC-1:0] r_enable;
   logic            r_ack;
   logic [31:0]     r_rdt;
   logic            r_irq;

   logic            w_access;
   logic            w_wr_pending;
   logic            w_wr_enable;
   logic [NSRC-1:0] w_active;
   logic [4:0]      w_id;
   logic [31:0]     w_rdsel;
   logic [NSRC-1:0] w_pending_nxt;
   logic            w_unused_dat;

   assign w_access     = bus.i_wb_cyc & bus.i_wb_stb & ~r_ack;
   assign w_wr_pending = w_access & bus.i_wb_we & (bus.i_wb_adr == 2'd0);
   assign w_wr_enable  = w_access & bus.i_wb_we & (bus.i_wb_adr == 2'd1);
   assign w_active     = r_pending & r_enable;
   assign w_unused_dat = ^bus.i_wb_dat[31:NSRC];

   // Scan from the top so the lowest-numbered active source wins.
   always_comb begin
      w_id = 5'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (w_active[i]) w_id = 5'(i + 1);
      end
   end

   always_comb begin
      w_rdsel = '0;
      case (bus.i_wb_adr)
         2'd0:    w_rdsel[NSRC-1:0] = r_pending;
         2'd1:    w_rdsel[NSRC-1:0] = r_enable;
         2'd2:    w_rdsel[NSRC-1:0] = w_active;
         default: w_rdsel[4:0]      = w_id;
      endcase
   end

`ifdef ROCKETCPU_IRQCTRL_EDGE_EN
   logic [NSRC-1:0] r_hist;
   logic [NSRC-1:0] w_clr;

   // A new rising edge beats a same-edge W1C of that bit.
   assign w_clr         = w_wr_pending ? bus.i_wb_dat[NSRC-1:0] : '0;
   assign w_pending_nxt = (r_pending & ~w_clr) | (i_irq & ~r_hist);

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) r_hist <= '0;
      else          r_hist <= i_irq;
   end
`else
   logic w_unused_wrp;

   assign w_unused_wrp  = w_wr_pending;
   assign w_pending_nxt = i_irq;
`endif

   always_ff @(posedge i_wb_clk) begin
      if (i_wb_rst) begin
         r_pending <= '0;
         r_enable  <= '0;
         r_ack     <= 1'b0;
         r_rdt     <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         r_ack     <= w_access;
         r_irq     <= |w_active;
         if (w_wr_enable) r_enable <= bus.i_wb_dat[NSRC-1:0];
         if (w_access)    r_rdt    <= w_rdsel;
      end
   end

   assign bus.o_wb_ack = r_ack;
   assign bus.o_wb_rdt = r_rdt;
   assign o_irq        = r_irq;

endmodule

// File: tb/tb_rocketcpu_irqctrl.sv
// Self-checking bench for rocketcpu_irqctrl: directed scenarios plus randomized traffic
// compared against a register-level behavioural model.
module tb_rocketcpu_irqctrl;
   localparam int NSRC = 8;

   logic            clk = 1'b0;
   logic            d_rst;
   logic [NSRC-1:0] d_irq;
   logic            d_cyc, d_stb, d_we;
   logic [1:0]      d_adr;
   logic [31:0]     d_dat;
   logic            o_irq;

   rocketcpu_irqctrl_if bus_if ();

   rocketcpu_irqctrl #(.NSRC(NSRC)) dut (
      .i_wb_clk (clk),
      .i_wb_rst (d_rst),
      .i_irq    (d_irq),
      .bus      (bus_if),
      .o_irq    (o_irq)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   logic [NSRC-1:0] m_pend, m_en, m_hist;
   logic            m_ack, m_irq;
   logic [31:0]     m_rdt;

   function automatic logic [4:0] lowest_id(input logic [NSRC-1:0] v);
      for (int i = 0; i < NSRC; i++) if (v[i]) return 5'(i + 1);
      return 5'd0;
   endfunction

   task automatic step();
      logic            acc;
      logic [31:0]     rd;
      logic [NSRC-1:0] dat_lo, np, ne;
      bus_if.i_wb_cyc = d_cyc;
      bus_if.i_wb_stb = d_stb;
      bus_if.i_wb_we  = d_we;
      bus_if.i_wb_adr = d_adr;
      bus_if.i_wb_dat = d_dat;
      dat_lo = d_dat[NSRC-1:0];
      acc = !d_rst && d_cyc && d_stb && !m_ack;
      if (d_rst) begin
         m_pend = '0; m_en = '0; m_hist = '0; m_irq = 1'b0; m_ack = 1'b0; m_rdt = '0;
      end else begin
         case (d_adr)
            2'd0:    rd = 32'(m_pend);
            2'd1:    rd = 32'(m_en);
            2'd2:    rd = 32'(m_pend & m_en);
            default: rd = 32'(lowest_id(m_pend & m_en));
         endcase
`ifdef ROCKETCPU_IRQCTRL_EDGE_EN
         np = m_pend;
         if (acc && d_we && d_adr == 2'd0) np = np & ~dat_lo;
         np = np | (d_irq & ~m_hist);
         m_hist = d_irq;
`else
         np = d_irq;
`endif
         ne = (acc && d_we && d_adr == 2'd1) ? dat_lo : m_en;
         m_irq = (m_pend & m_en) != 0;
         m_ack = acc;
         if (acc) m_rdt = rd;
         m_pend = np;
         m_en = ne;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_adr = 2'd0; d_dat = '0;
   endtask

   // One access followed by its ack cycle; returns data seen while ack was high.
   task automatic bus_op(input logic [1:0] adr, input logic [31:0] dat, input logic we,
                         output logic [31:0] rd);
      d_cyc = 1'b1; d_stb = 1'b1; d_we = we; d_adr = adr; d_dat = dat;
      step();
      rd = bus_if.o_wb_rdt;
      idle();
      step();
   endtask

   task automatic do_reset();
      d_rst = 1'b1; idle(); d_irq = '0;
      step(); step();
      d_rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      do_reset();
      n_vec++;
      if (bus_if.o_wb_ack !== 1'b0 || o_irq !== 1'b0 || bus_if.o_wb_rdt !== 32'h0) begin
         n_err++;
         $display("FAIL reset_outputs: ack=%b irq=%b rdt=%h, required 0 0 00000000",
                  bus_if.o_wb_ack, o_irq, bus_if.o_wb_rdt);
      end
      bus_op(2'd1, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL reset_enable: got %h, required 0", rd); end
      bus_op(2'd0, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL reset_pending: got %h, required 0", rd); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] pat;
      idle(); d_irq = '0;
      d_cyc = 1'b1; d_stb = 1'b1; d_adr = 2'd1;
      for (int i = 0; i < 4; i++) begin
         pat[i] = bus_if.o_wb_ack;
         step();
      end
      idle(); step();
      n_vec++;
      if (pat !== 4'b1010) begin
         n_err++; $display("FAIL ack_pattern: got %b (cycle0 at lsb), required 1010", pat);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      do_reset();
      d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_adr = 2'd1; d_dat = 32'hFF;
      d_rst = 1'b1;
      step();
      n_vec++;
      if (bus_if.o_wb_ack !== 1'b0) begin
         n_err++; $display("FAIL reset_abort_ack: got %b, required 0", bus_if.o_wb_ack);
      end
      d_rst = 1'b0; idle(); step();
      bus_op(2'd1, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL reset_abort_enable: got %h, required 0", rd); end
   endtask

`ifdef ROCKETCPU_IRQCTRL_EDGE_EN
   task automatic test_edge();
      logic [31:0] rd;
      do_reset();
      bus_op(2'd1, 32'h01, 1'b1, rd);
      d_irq = 8'h01; step();
      n_vec++;
      if (o_irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_k: got %b, required 0", o_irq); end
      step();
      n_vec++;
      if (o_irq !== 1'b1) begin n_err++; $display("FAIL edge_irq_k1: got %b, required 1", o_irq); end
      bus_op(2'd3, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'd1) begin n_err++; $display("FAIL edge_id1: got %h, required 1", rd); end

      do_reset();
      bus_op(2'd1, 32'hFF, 1'b1, rd);
      d_irq = 8'h0A; step();
      d_irq = 8'h00; step();
      bus_op(2'd2, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'h0A) begin n_err++; $display("FAIL edge_active: got %h, required 0000000a", rd); end
      bus_op(2'd3, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'd2) begin n_err++; $display("FAIL edge_id2: got %h, required 2", rd); end
      bus_op(2'd0, 32'h02, 1'b1, rd);
      bus_op(2'd0, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'h08) begin n_err++; $display("FAIL edge_w1c: got %h, required 00000008", rd); end
      bus_op(2'd3, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'd4) begin n_err++; $display("FAIL edge_id4: got %h, required 4", rd); end
      d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_adr = 2'd0; d_dat = 32'h08;
      step();
      n_vec++;
      if (o_irq !== 1'b1) begin n_err++; $display("FAIL edge_irq_at_ack: got %b, required 1", o_irq); end
      idle(); step();
      n_vec++;
      if (o_irq !== 1'b0) begin n_err++; $display("FAIL edge_irq_fall: got %b, required 0", o_irq); end
      bus_op(2'd3, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL edge_id0: got %h, required 0", rd); end

      // same-edge rising request and W1C of source 3
      d_irq = 8'h08; step();
      d_irq = 8'h00; step();
      d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_adr = 2'd0; d_dat = 32'h08; d_irq = 8'h08;
      step();
      idle(); step();
      bus_op(2'd0, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd[3] !== 1'b1) begin n_err++; $display("FAIL edge_set_wins: pending=%h, required bit3=1", rd); end
   endtask
`else
   task automatic test_level();
      logic [31:0] rd;
      do_reset();
      bus_op(2'd1, 32'h04, 1'b1, rd);
      d_irq = 8'h04; step(); step(); step();
      n_vec++;
      if (o_irq !== 1'b1) begin n_err++; $display("FAIL level_irq_on: got %b, required 1", o_irq); end
      d_irq = 8'h00; step();
      n_vec++;
      if (o_irq !== 1'b1) begin n_err++; $display("FAIL level_irq_hold: got %b, required 1", o_irq); end
      step();
      n_vec++;
      if (o_irq !== 1'b0) begin n_err++; $display("FAIL level_irq_off: got %b, required 0", o_irq); end
      bus_op(2'd0, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'h0) begin n_err++; $display("FAIL level_pending_zero: got %h, required 0", rd); end
      d_irq = 8'h04; step();
      bus_op(2'd0, 32'hFF, 1'b1, rd);
      bus_op(2'd0, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'h04) begin n_err++; $display("FAIL level_w1c_ignored: got %h, required 00000004", rd); end
      bus_op(2'd3, 32'h0, 1'b0, rd);
      n_vec++;
      if (rd !== 32'd3) begin n_err++; $display("FAIL level_id3: got %h, required 3", rd); end
   endtask
`endif

   task automatic test_random();
      logic [31:0] rv;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         d_rst = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) == 0) d_irq = NSRC'($urandom);
         d_cyc = ($urandom_range(0, 2) != 0);
         d_stb = ($urandom_range(0, 3) != 0);
         d_we  = $urandom_range(0, 1);
         d_adr = 2'($urandom);
         rv = $urandom;
         d_dat = ($urandom_range(0, 1) != 0) ? rv : (32'h1 << $urandom_range(0, NSRC - 1));
         step();
         n_vec++;
         if (bus_if.o_wb_ack !== m_ack || o_irq !== m_irq) begin
            n_err++;
            $display("FAIL rand_ack_irq[%0d]: ack=%b irq=%b, required ack=%b irq=%b",
                     i, bus_if.o_wb_ack, o_irq, m_ack, m_irq);
         end
         if (m_ack) begin
            n_vec++;
            if (bus_if.o_wb_rdt !== m_rdt) begin
               n_err++;
               $display("FAIL rand_rdt[%0d]: got %h, required %h", i, bus_if.o_wb_rdt, m_rdt);
            end
         end
      end
      d_rst = 1'b0; idle(); step();
   endtask

   initial begin
      d_rst = 1'b1; d_irq = '0; idle();
      m_pend = '0; m_en = '0; m_hist = '0; m_ack = 1'b0; m_irq = 1'b0; m_rdt = '0;
      test_reset();
      test_back_to_back();
      test_reset_mid();
`ifdef ROCKETCPU_IRQCTRL_EDGE_EN
      test_edge();
`else
      test_level();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/rocketcpu_irqctrl.md
ROCKETCPU_IRQCTRL -- requirements
Module: rocketcpu_irqctrl

Interface
REQ-001 Parameter NSRC, default 8, number of interrupt sources; legal range 1..31.
REQ-002 i_wb_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_wb_rst  input  1  reset, synchronous, active-high.
REQ-004 i_irq  input  NSRC  interrupt requests from peripherals, e.g. a timer o_irq; synchronous to i_wb_clk, bit n = source n.
REQ-005 i_wb_adr  input  2  register select, word index: 0 PENDING, 1 ENABLE, 2 ACTIVE, 3 ID.
REQ-006 i_wb_dat  input  32  write data.
REQ-007 i_wb_we  input  1  write strobe, qualified by i_wb_cyc and i_wb_stb.
REQ-008 i_wb_cyc  input  1  bus cycle valid.
REQ-009 i_wb_stb  input  1  bus strobe.
REQ-010 o_wb_rdt  output  32  registered read data; bits above the field width read 0.
REQ-011 o_wb_ack  output  1  single-cycle bus acknowledge.
REQ-012 o_irq  output  1  combined interrupt to the CPU, registered.

Function
REQ-013 Access = i_wb_cyc & i_wb_stb & ~o_wb_ack; o_wb_ack SHALL be 1 on the cycle after an access and 0 otherwise, so back-to-back accesses ack every other cycle.
REQ-014 Writes and read-data capture SHALL occur on the access edge; o_wb_rdt is valid while o_wb_ack is 1.
REQ-015 PENDING[NSRC-1:0]: read returns pending; write clears each bit where i_wb_dat is 1 (write-1-to-clear), 0 bits unaffected.
REQ-016 ENABLE[NSRC-1:0]: read/write mask; new value takes effect the edge after the write.
REQ-017 ACTIVE[NSRC-1:0] = pending & enable; read-only, writes ignored.
REQ-018 ID[4:0] = 1 + index of lowest-numbered active source, 0 when no bit active; read-only, writes ignored.
REQ-019 o_irq SHALL be registered from |(pending & enable): one edge of latency after pending/enable change.
REQ-020 Source pending-set condition is selected per REQ-026/027; a set and a W1C clear of the same bit on the same edge SHALL leave the bit set.
REQ-021 Sources with no set event keep pending until cleared; enable does not gate capture, only o_irq/ACTIVE/ID.
REQ-022 Access while i_wb_rst is 1 SHALL be ignored and not acknowledged.

Reset
REQ-023 On an edge with i_wb_rst=1: pending=0, enable=0, input history register=0, o_irq=0, o_wb_ack=0, o_wb_rdt=0.
REQ-024 Reset mid-transaction SHALL abort the access; no write takes effect and no ack is issued for it.
REQ-025 Since history resets to 0, a source held high across reset release SHALL register as a rising edge on the first edge after release.

Configuration
REQ-026 With ROCKETCPU_IRQCTRL_EDGE_EN defined: pending[n] sets on the edge where i_irq[n]=1 and history[n]=0; history samples i_irq each edge; W1C per REQ-015.
REQ-027 Without ROCKETCPU_IRQCTRL_EDGE_EN: pending SHALL equal i_irq registered each edge (level mode); PENDING writes ignored; history register absent.

Verification
REQ-028 EDGE_EN, ENABLE=0x01, i_irq[0] 0->1 sampled edge k -> PENDING bit0=1 after edge k, o_irq=1 after edge k+1, ID reads 1.
REQ-029 EDGE_EN, pending=0x0A, ENABLE=0xFF -> ACTIVE=0x0A, ID=2; write PENDING=0x02 -> PENDING=0x08, ID=4; write 0x08 -> ID=0, o_irq falls one edge after ack.
REQ-030 EDGE_EN, rising edge on source 3 on the same edge as W1C of 0x08 -> PENDING bit3 remains 1.
REQ-031 Level mode, i_irq=0x04 held, ENABLE=0x04 -> o_irq=1; i_irq to 0 -> PENDING=0 next edge, o_irq=0 edge after; PENDING write 0xFF has no effect.
REQ-032 i_wb_cyc/stb held high 4 cycles -> o_wb_ack pattern 0,1,0,1; reset asserted during access -> no ack, ENABLE unchanged at 0.
